reg_writeback: RTL

// - Write-side companion of register_file: merges ALU and LSU results onto the single write port
//   (reg_wen/rd/reg_in).
// - Keeps a per-register pending-write scoreboard so decode can stall RAW hazards on rs1/rs2.
// - Sits between EXU/LSU and register_file; one write per cycle, one cycle of latency.

---
 rtl/reg_writeback.sv | 123 ++++++++++++
 1 files changed

// File: rtl/reg_writeback.sv
// reg_writeback: write-side companion of register_file.
//   Merges ALU and LSU results onto the single register-file write port and
//   keeps a per-register pending-write scoreboard so decode can stall on RAW
//   hazards for rs1/rs2. One write per cycle, one cycle of latency.
//
// Optional feature: define WB_BYPASS_EN to enable write-stage forwarding
// (fwd1_hit/fwd2_hit/fwd_data). When undefined these outputs are tied to 0.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   issue_valid, issue_rd     decode marks issue_rd as pending
//   rs1, rs2                  decode source queries
//   rs1_busy, rs2_busy        source has a pending write (combinational)
//   alu_valid/ready/rd/data   ALU result handshake
//   lsu_valid/ready/rd/data   load result handshake
//   reg_wen, rd, reg_in       registered register-file write port
//   sb_err                    sticky: issue to an already-pending rd
//   fwd1_hit, fwd2_hit        write-stage value matches rs1/rs2
//   fwd_data                  forwarded value (= reg_in)
module reg_writeback #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter bit LSU_PRIO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            reg_wen,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] reg_in,
  output logic            sb_err,
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd_data
);

  logic            alu_acc;
  logic            lsu_acc;
  logic            acc;
  logic [4:0]      acc_rd;
  logic [XLEN-1:0] acc_data;
  logic            issue_hit;
  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_set;
  logic [NREG-1:0] sb_clr;
  logic [NREG-1:0] sb_next;

  // The priority source is always ready; the other one yields whenever the
  // priority source is presenting a result.
  always_comb begin
    if (LSU_PRIO) begin
      lsu_ready = 1'b1;
      alu_ready = !lsu_valid;
    end else begin
      alu_ready = 1'b1;
      lsu_ready = !alu_valid;
    end
  end

  assign alu_acc  = alu_valid && alu_ready;
  assign lsu_acc  = lsu_valid && lsu_ready;
  assign acc      = alu_acc || lsu_acc;
  assign acc_rd   = lsu_acc ? lsu_rd   : alu_rd;
  assign acc_data = lsu_acc ? lsu_data : alu_data;

  assign issue_hit = issue_valid && (issue_rd != 5'd0);
  assign sb_set    = issue_hit ? (NREG'(1) << issue_rd) : '0;
  assign sb_clr    = acc       ? (NREG'(1) << acc_rd)   : '0;
  // Set is applied after clear so a same-cycle issue to the retiring rd
  // leaves the new write pending.
  assign sb_next   = (sb & ~sb_clr) | sb_set;

  assign rs1_busy = sb[rs1] && (rs1 != 5'd0);
  assign rs2_busy = sb[rs2] && (rs2 != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_wen <= 1'b0;
      rd      <= 5'd0;
      reg_in  <= '0;
      sb      <= '0;
      sb_err  <= 1'b0;
    end else begin
      // x0 results are consumed without a write; rd/reg_in keep the last
      // real write so forwarding never sees a stale x0 value.
      reg_wen <= acc && (acc_rd != 5'd0);
      if (acc && (acc_rd != 5'd0)) begin
        rd     <= acc_rd;
        reg_in <= acc_data;
      end
      sb <= sb_next;
      // Re-issue is only an error if the bit is still pending after this
      // cycle's retirement.
      if (issue_hit && |(sb & ~sb_clr & sb_set)) begin
        sb_err <= 1'b1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd1_hit = reg_wen && (rd == rs1) && (rs1 != 5'd0);
  assign fwd2_hit = reg_wen && (rd == rs2) && (rs2 != 5'd0);
  assign fwd_data = reg_in;
`else
  assign fwd1_hit = 1'b0;
  assign fwd2_hit = 1'b0;
  assign fwd_data = '0;
`endif

endmodule
